vdff_share_arbiter: RTL and testbench
=====================================

Name: vdff_share_arbiter

Overview:
- Round-robin scheduler sharing one parameterised registered delay pipeline among NREQ requesters.
- Each cycle it grants at most one requester and captures that requester's word plus its ID into the shared pipeline.
- A granted requester may hold ownership for a burst of up to BURST consecutive cycles.
- Sits in front of the registered datapath; downstream consumers see one tagged, valid-qualified stream.

Parameters:
- SIZE, 5, data word width in bits (>=1)
- NREQ, 4, number of requesters (>=2)
- DEPTH, 2, shared pipeline stages; equals output latency in cycles (>=1)
- BURST, 2, max consecutive grants to one owner (>=1)
- IDW, derived localparam = ceil(log2(NREQ)), min 1; not overridable

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request, level
- in_data  input  NREQ*SIZE  requester i's word at bits [i*SIZE +: SIZE]
- gnt  output  NREQ  one-hot or zero; combinational; transfer accepted this cycle
- out_data  output  SIZE  word leaving the last pipeline stage
- out_id  output  IDW  requester index of out_data
- out_valid  output  1  out_data/out_id are valid
- busy  output  1  any pipeline stage holds valid data, or the FSM is in OWN

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async assert) clears the following:
  - all stage valids, data and IDs → 0
  - ptr → 0, owner → 0, cnt → 0, state → IDLE
  - out_valid = 0, out_data = 0, out_id = 0, busy = 0
- Reset mid-operation:
  - in-flight words are dropped, never emitted
  - gnt goes to 0 combinationally while rst_n is low
- Release of rst_n is synchronised externally; no internal synchroniser.
- pick = first i with req[i] = 1, scanning ptr, ptr+1, … NREQ-1, 0, … (wrap-around modulo NREQ); none if req = 0.
- FSM states IDLE and OWN; cnt is the count of consecutive grants to owner.
- IDLE:
  - gnt = onehot(pick), or 0 if there is no request.
  - On a grant: owner ← pick, cnt ← 1, ptr ← (pick+1) mod NREQ, state → OWN if BURST > 1, else stay IDLE.
- OWN, req[owner] = 1 and cnt < BURST: gnt = onehot(owner), cnt ← cnt+1; ptr unchanged.
- OWN, req[owner] = 0 or cnt = BURST:
  - Re-arbitrate in the same cycle (no bubble) using ptr; owner has lowest priority because ptr is past it.
  - On a pick, handle it as an IDLE grant.
  - With no pick, gnt = 0 and state → IDLE.
- BURST = 1 degenerates to pure per-cycle round-robin; OWN is never entered.
- Capture: when |gnt, at posedge stage0 ← {valid = 1, id = index, data = in_data slice}; otherwise stage0.valid ← 0.
- Stage k ← stage k−1 every cycle, with no stall and no backpressure.
- Outputs are driven from stage DEPTH−1.
- Latency: a word granted in cycle T appears with out_valid = 1 in cycle T+DEPTH.
- Throughput is 1 word per cycle.
- Requests that appear or drop mid-cycle affect only the combinational gnt of that cycle; requesters must hold data stable while req = 1.
- gnt is never asserted for a requester whose req = 0; at most one bit is set at any time.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: IDLE = 1'b0, OWN = 1'b1
  - a clog2 constant function used for IDW
- One natural sub-module: rr_pick.
  - Combinational: inputs req and ptr; outputs found and index.
  - Parameterised by NREQ; reusable by other arbiters.
- Pipeline stages stay inline as a generate loop.

Test Plan (NREQ=4, SIZE=5, DEPTH=2, BURST=2):
- Reset, then req = 4'b0101 held, in_data slot0 = 5'h03, slot2 = 5'h11 → gnt sequence 0,0,2,2,0,0 (indices); out_id follows the same sequence starting 2 cycles after the first grant; out_data is 03,03,11,11,…
- req = 4'b1000 only → gnt = 4'b1000 every cycle, re-granted after each 2-cycle burst without a bubble; out_valid stays continuously high after 2 cycles.
- Owner 1 drops req after 1 grant while req[3] = 1 → next cycle gnt = 4'b1000 (same-cycle re-arbitration); ptr wraps to 0 after owner 3.
- All req = 1111 for 8 cycles → grant order 0,0,1,1,2,2,3,3; no requester starves.
- rst_n pulsed low mid-stream with 2 words in flight → out_valid = 0 immediately; those words are never emitted; after release the first grant goes to requester 0 (ptr = 0).
- req = 0 → gnt = 0; out_valid falls 2 cycles after the last grant; busy = 0 once the pipeline is empty and the FSM is in IDLE.

Source files
------------

// File: rtl/vdff_share_arbiter_pkg.sv
// Shared types and helpers for the shared-pipeline round-robin arbiter.
package vdff_share_arbiter_pkg;

  // Arbiter FSM: IDLE when nobody owns the pipeline, OWN while a burst runs.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1 so a single-bit index is never zero-width.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vdff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module rr_pick
  import vdff_share_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  index
);

  // Scan offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    index = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[IDW'((int'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        index = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/vdff_share_arbiter.sv
// Round-robin burst arbiter feeding one shared, tagged, fixed-latency pipeline.
module vdff_share_arbiter
  import vdff_share_arbiter_pkg::*;
#(
  parameter  int SIZE  = 5,
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 2,
  parameter  int BURST = 2,
  localparam int IDW   = clog2_min1(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] in_data,
  output logic [NREQ-1:0]      gnt,
  output logic [SIZE-1:0]      out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int CNTW = clog2_min1(BURST + 1);

  typedef struct packed {
    logic            valid;
    logic [IDW-1:0]  id;
    logic [SIZE-1:0] data;
  } stage_t;

  state_t          state;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  ptr;
  logic [CNTW-1:0] cnt;
  logic            found;
  logic [IDW-1:0]  pick;
  logic            keep;
  logic            take;
  logic [IDW-1:0]  sel;
  stage_t          stage_q [DEPTH];

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .index (pick)
  );

  // The current owner keeps the grant while it still requests and has burst budget left.
  assign keep = (state == OWN) && req[owner] && (cnt < CNTW'(BURST));

  // Grant selection: continue the burst, else re-arbitrate in the same cycle; silent in reset.
  always_comb begin
    take = 1'b0;
    sel  = owner;
    if (!rst_n) begin
      take = 1'b0;
    end else if (keep) begin
      take = 1'b1;
      sel  = owner;
    end else if (found) begin
      take = 1'b1;
      sel  = pick;
    end
  end

  assign gnt = take ? (NREQ'(1) << sel) : '0;

  // Arbiter FSM: burst counting, ownership hand-over and pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else if (keep) begin
      cnt <= cnt + CNTW'(1);
    end else if (found) begin
      owner <= pick;
      cnt   <= CNTW'(1);
      ptr   <= (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
      state <= (BURST > 1) ? OWN : IDLE;
    end else begin
      state <= IDLE;
    end
  end

  // Shared delay line: stage 0 captures the granted word, later stages shift every cycle.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Capture the granted requester's word and index; an idle cycle only clears valid.
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data and id are reset too, so the outputs read zero after reset, not stale values.
        if (!rst_n) begin
          stage_q[0] <= '0;
        end else begin
          stage_q[0].valid <= take;
          if (take) begin
            stage_q[0].id   <= sel;
            stage_q[0].data <= in_data[int'(sel) * SIZE +: SIZE];
          end
        end
      end
    end else begin : g_tail
      // Unconditional shift; there is no stall or backpressure.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q[k] <= '0;
        else        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_id    = stage_q[DEPTH-1].id;
  assign out_data  = stage_q[DEPTH-1].data;

  // Busy while any stage holds a word or a burst is in progress.
  always_comb begin
    busy = (state == OWN);
    for (int k = 0; k < DEPTH; k++) busy = busy | stage_q[k].valid;
  end

endmodule

// File: tb/tb_vdff_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_vdff_share_arbiter;

  localparam int SIZE  = 5;
  localparam int NREQ  = 4;
  localparam int DEPTH = 2;
  localparam int BURST = 2;
  localparam int IDW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] in_data;
  logic [NREQ-1:0]      gnt;
  logic [SIZE-1:0]      out_data;
  logic [IDW-1:0]       out_id;
  logic                 out_valid;
  logic                 busy;

  vdff_share_arbiter #(
    .SIZE (SIZE),
    .NREQ (NREQ),
    .DEPTH(DEPTH),
    .BURST(BURST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .in_data  (in_data),
    .gnt      (gnt),
    .out_data (out_data),
    .out_id   (out_id),
    .out_valid(out_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: what each requester holds, grant history, and a queue of words in flight.
  typedef struct {
    bit valid;
    int id;
    int data;
  } word_t;

  word_t           pipe[$];
  logic [SIZE-1:0] slot [NREQ];
  int              m_last;   // requester granted most recently
  int              m_run;    // consecutive grants it has received
  int              m_scan;   // where the next fresh search starts
  bit              m_prev;   // a grant happened in the previous cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    word_t z;
    z.valid = 1'b0;
    z.id    = 0;
    z.data  = 0;
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
    m_last = 0;
    m_run  = 0;
    m_scan = 0;
    m_prev = 1'b0;
  endtask

  // Who should be granted for request vector r; -1 for nobody.
  task automatic model_grant(input logic [NREQ-1:0] r, output int g, output bit keep);
    int j;
    keep = m_prev && (m_run < BURST) && r[m_last];
    g = -1;
    if (keep) begin
      g = m_last;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_scan + k) % NREQ;
        if (g < 0 && r[j]) g = j;
      end
    end
  endtask

  // One clock cycle: drive, check combinational grant and current outputs, advance model.
  task automatic step(input logic [NREQ-1:0] r, input int exp_idx, input string tag);
    int              g;
    bit              keep;
    bit              any_valid;
    word_t           w;
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] dir_gnt;
    req = r;
    for (int i = 0; i < NREQ; i++) in_data[i*SIZE +: SIZE] = slot[i];
    #2;
    model_grant(r, g, keep);
    exp_gnt = (g >= 0) ? (NREQ'(1) << g) : '0;
    check({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    if (exp_idx != -2) begin
      dir_gnt = (exp_idx >= 0) ? (NREQ'(1) << exp_idx) : '0;
      check({tag, " gnt_directed"}, 32'(gnt), 32'(dir_gnt));
    end
    check({tag, " out_valid"}, 32'(out_valid), 32'(pipe[0].valid));
    if (pipe[0].valid) begin
      check({tag, " out_id"}, 32'(out_id), 32'(pipe[0].id));
      check({tag, " out_data"}, 32'(out_data), 32'(pipe[0].data));
    end
    any_valid = 1'b0;
    foreach (pipe[i]) any_valid = any_valid | pipe[i].valid;
    check({tag, " busy"}, 32'(busy), 32'(any_valid || (BURST > 1 && m_prev)));
    @(posedge clk);
    #1;
    w.valid = (g >= 0);
    w.id    = (g >= 0) ? g : 0;
    w.data  = (g >= 0) ? int'(slot[g]) : 0;
    pipe.push_back(w);
    void'(pipe.pop_front());
    if (keep) begin
      m_run++;
    end else if (g >= 0) begin
      m_last = g;
      m_run  = 1;
      m_scan = (g + 1) % NREQ;
    end
    m_prev = (g >= 0);
  endtask

  initial begin
    logic [NREQ-1:0] r;
    rst_n   = 1'b0;
    req     = '0;
    in_data = '0;
    for (int i = 0; i < NREQ; i++) slot[i] = SIZE'(i + 1);
    model_reset();

    // Reset state.
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_id", 32'(out_id), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset gnt", 32'(gnt), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two requesters held: bursts of two alternate 0,0,2,2,0,0.
    slot[0] = 5'h03;
    slot[2] = 5'h11;
    step(4'b0101, 0, "alt0");
    step(4'b0101, 0, "alt1");
    step(4'b0101, 2, "alt2");
    step(4'b0101, 2, "alt3");
    step(4'b0101, 0, "alt4");
    step(4'b0101, 0, "alt5");

    // Single requester re-granted after each burst without a bubble.
    slot[3] = 5'h1a;
    for (int i = 0; i < 6; i++) step(4'b1000, 3, "solo3");

    // Owner 1 drops after one grant; requester 3 takes over in the same cycle, ptr wraps to 0.
    step(4'b1010, 1, "drop_own1");
    step(4'b1000, 3, "drop_next3");
    step(4'b1000, 3, "hold3");
    step(4'b1001, 0, "wrap0");
    step(4'b1000, 3, "back3");

    // Drain: out_valid falls two cycles after the last grant, then busy clears.
    for (int i = 0; i < 4; i++) step(4'b0000, -1, "drain");
    check("drained busy", 32'(busy), 32'd0);

    // All request: fair order 0,0,1,1,2,2,3,3.
    slot[1] = 5'h0c;
    step(4'b1111, 0, "all0a");
    step(4'b1111, 0, "all0b");
    step(4'b1111, 1, "all1a");
    step(4'b1111, 1, "all1b");
    step(4'b1111, 2, "all2a");
    step(4'b1111, 2, "all2b");
    step(4'b1111, 3, "all3a");
    step(4'b1111, 3, "all3b");

    // Reset mid-stream with two words in flight: they vanish and ptr restarts at 0.
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset gnt", 32'(gnt), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 0, "post_reset0");
    step(4'b1111, 0, "post_reset1");
    step(4'b0000, -1, "post_reset2");
    step(4'b0000, -1, "post_reset3");
    step(4'b0000, -1, "post_reset4");

    // Random traffic; a requester's word only changes while it is not requesting.
    r = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) if (!r[i] && !req[i]) slot[i] = SIZE'($urandom);
      step(r, -2, "rand");
    end
    for (int i = 0; i < DEPTH + 1; i++) step(4'b0000, -1, "final_drain");
    check("final busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
